// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Grants one DMA request channel at a time to the bus. The arbiter asks
//   the bus master for the bus with HRQ and waits for HLDA. It then grants
//   one channel on DACK and holds that grant until the transfer ends. Each
//   transfer runs through IDLE -> REQ -> GRANT -> RELEASE -> IDLE. The
//   winner is the lowest requesting index in fixed mode. In rotating mode
//   the search starts one past the last served channel.
//
// Optional feature (macro DMA_DREQ_SYNC_EN):
//   When defined, each DREQ bit passes through a 2-flop synchroniser before
//   use. This adds two cycles of request latency. When undefined, DREQ is
//   used directly.
//
// Ports
//   CLK        in   1         system clock, rising edge
//   RESET      in   1         asynchronous active-high reset
//   DREQ       in   CHANNELS  per-channel request
//   MASK       in   CHANNELS  per-channel mask, 1 = ignore channel
//   ROTATE     in   1         0 = fixed priority, 1 = rotating (sampled in IDLE)
//   HLDA       in   1         hold acknowledge from bus master
//   TC         in   1         terminal count / end of process for active channel
//   HRQ        out  1         hold request to bus master
//   DACK       out  CHANNELS  one-hot grant
//   ACTIVE_CH  out  CHW       index of granted channel, valid while BUSY
//   BUSY       out  1         high in GRANT and RELEASE
module dma_priority_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CHW      = $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] DREQ,
  input  logic [CHANNELS-1:0] MASK,
  input  logic                ROTATE,
  input  logic                HLDA,
  input  logic                TC,
  output logic                HRQ,
  output logic [CHANNELS-1:0] DACK,
  output logic [CHW-1:0]      ACTIVE_CH,
  output logic                BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] dreq_eff;
  logic [CHANNELS-1:0] ereq;
  logic [CHW-1:0]      pri_q, pri_d;
  logic                rot_mode_q;
  logic [CHW-1:0]      search_base;
  logic [CHW-1:0]      winner;
  logic [CHW-1:0]      next_pri;
  logic                end_of_grant;

  logic                hrq_d;
  logic [CHANNELS-1:0] dack_d;
  logic [CHW-1:0]      active_ch_d;
  logic                busy_d;

`ifdef DMA_DREQ_SYNC_EN
  logic [CHANNELS-1:0] sync_q1, sync_q2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= DREQ;
      sync_q2 <= sync_q1;
    end
  end

  assign dreq_eff = sync_q2;
`else
  assign dreq_eff = DREQ;
`endif

  assign ereq = dreq_eff & ~MASK;

  // The priority pointer only matters in rotating mode. Fixed mode always
  // searches upward from channel 0.
  assign search_base = rot_mode_q ? pri_q : '0;

  // Circular search from search_base. The first set bit wins.
  always_comb begin
    int idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(search_base) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && ereq[CHW'(idx)]) begin
        winner = CHW'(idx);
        found  = 1'b1;
      end
    end
  end

  // After a channel is served it becomes lowest priority.
  assign next_pri = (ACTIVE_CH == CHW'(CHANNELS - 1)) ? '0 : ACTIVE_CH + CHW'(1);

  assign end_of_grant = TC || !dreq_eff[ACTIVE_CH] || MASK[ACTIVE_CH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the next values of the registered outputs. A bus revoke
  // (HLDA low in GRANT) is checked before end-of-transfer. This means a
  // simultaneous TC is ignored and the priority pointer is left alone.
  always_comb begin
    state_d     = state_q;
    hrq_d       = HRQ;
    dack_d      = DACK;
    active_ch_d = ACTIVE_CH;
    busy_d      = BUSY;
    pri_d       = pri_q;
    case (state_q)
      ST_IDLE: begin
        hrq_d  = 1'b0;
        dack_d = '0;
        busy_d = 1'b0;
        if (|ereq) begin
          state_d = ST_REQ;
          hrq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (HLDA && (|ereq)) begin
          state_d     = ST_GRANT;
          dack_d      = CHANNELS'(1) << winner;
          active_ch_d = winner;
          busy_d      = 1'b1;
        end else if (!(|ereq)) begin
          state_d = ST_RELEASE;
          hrq_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!HLDA) begin
          state_d = ST_IDLE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          busy_d  = 1'b0;
        end else if (end_of_grant) begin
          state_d = ST_RELEASE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          busy_d  = 1'b1;
          pri_d   = rot_mode_q ? next_pri : '0;
        end
      end
      ST_RELEASE: begin
        hrq_d  = 1'b0;
        dack_d = '0;
        if (!HLDA) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hrq_d   = 1'b0;
        dack_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Registered outputs, priority pointer and the priority mode latched in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HRQ        <= 1'b0;
      DACK       <= '0;
      ACTIVE_CH  <= '0;
      BUSY       <= 1'b0;
      pri_q      <= '0;
      rot_mode_q <= 1'b0;
    end else begin
      HRQ       <= hrq_d;
      DACK      <= dack_d;
      ACTIVE_CH <= active_ch_d;
      BUSY      <= busy_d;
      pri_q     <= pri_d;
      if (state_q == ST_IDLE) rot_mode_q <= ROTATE;
    end
  end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4, number of DMA request channels (legal 2..16).
REQ-002 Parameter CHW, default $clog2(CHANNELS), width of the channel index.
REQ-003 One clock; reset is asynchronous and active-high. Ports are named CLK and RESET.
REQ-004 CLK  input  1  system clock; all state updates on the rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 DREQ  input  CHANNELS  per-channel request, active-high.
REQ-007 MASK  input  CHANNELS  per-channel mask; 1 = channel ignored.
REQ-008 ROTATE  input  1  priority mode; 0 = fixed, 1 = rotating; sampled only in IDLE.
REQ-009 HLDA  input  1  hold acknowledge from bus master.
REQ-010 TC  input  1  terminal count / EOP pulse for the active channel.
REQ-011 HRQ  output  1  hold request to bus master.
REQ-012 DACK  output  CHANNELS  one-hot grant, active-high.
REQ-013 ACTIVE_CH  output  CHW  index of the granted channel; valid while BUSY=1.
REQ-014 BUSY  output  1  high in states GRANT and RELEASE.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, GRANT and RELEASE, with all outputs registered.
REQ-016 Effective request: EREQ = DREQ & ~MASK, computed on the (optionally synchronised) DREQ.
REQ-017 IDLE: if EREQ is non-zero in cycle n, go to REQ and drive HRQ=1 from cycle n+1.
REQ-018 REQ: hold HRQ=1 while HLDA=0, with no timeout.
- If HLDA=1 and EREQ is non-zero in cycle m: latch the winner, go to GRANT, DACK[winner]=1 and ACTIVE_CH=winner from cycle m+1.
- If EREQ becomes zero before HLDA arrives: go to RELEASE and drive HRQ=0.
REQ-019 Winner selection:
- Fixed mode: the lowest-index EREQ bit wins.
- Rotating mode: the search starts at pointer PRI, wraps CHANNELS-1 -> 0, and the first set bit wins.
REQ-020 GRANT: DACK stays stable and one-hot; later requests (including higher-priority ones) do not preempt.
REQ-021 GRANT exits to RELEASE on any of: TC=1; DREQ[ACTIVE_CH]=0; MASK[ACTIVE_CH]=1.
- DACK=0 and HRQ=0 from the next cycle.
REQ-022 HLDA=0 in GRANT (bus revoked): DACK=0 and HRQ=0 next cycle, go to IDLE, and do not update PRI.
REQ-023 RELEASE: hold HRQ=0 until HLDA=0, then go to IDLE; a new request SHALL NOT raise HRQ before this.
REQ-024 PRI update on GRANT->RELEASE in rotating mode: PRI <= (ACTIVE_CH+1) mod CHANNELS, so the served channel becomes lowest priority. In fixed mode PRI stays 0.
REQ-025 Simultaneous TC and HLDA=0 in GRANT: the HLDA=0 path (REQ-022) wins.
REQ-026 DACK SHALL never have more than one bit set; DACK is zero whenever the FSM is not in GRANT.

Reset
REQ-027 RESET=1 SHALL immediately force: state=IDLE, HRQ=0, DACK=0, ACTIVE_CH=0, BUSY=0, PRI=0, and synchroniser flops=0.
REQ-028 Reset mid-grant SHALL drop DACK and HRQ without waiting for HLDA; after release the block starts in IDLE.

Configuration
REQ-029 Macro DMA_DREQ_SYNC_EN.
- Defined: each DREQ bit passes through a 2-flop synchroniser, adding 2 cycles to the IDLE->HRQ latency and to GRANT's DREQ-drop detection.
- Undefined: DREQ is used directly with no added latency.

Verification (CHANNELS=4, macro undefined unless stated)
REQ-030 Fixed mode: DREQ=4'b0110, MASK=0, HLDA raised 3 cycles after HRQ -> DACK=4'b0010, ACTIVE_CH=1 one cycle after HLDA.
REQ-031 Rotating mode: channel 2 served, TC pulsed, then DREQ=4'b1101 -> next grant is channel 3, then 0, then 2.
REQ-032 Masking: DREQ=4'b0001, MASK=4'b0001 -> HRQ stays 0; clearing MASK -> HRQ=1 next cycle.
REQ-033 Bus revoke: HLDA dropped in GRANT with TC=1 in the same cycle -> DACK=0 next cycle, state IDLE, PRI unchanged.
REQ-034 RESET asserted mid-GRANT, asynchronous to CLK -> HRQ=0 and DACK=0 without a clock edge; with DMA_DREQ_SYNC_EN defined, a DREQ rise gives HRQ exactly 3 cycles later.
